// File: rtl/btn_cmd_arbiter.sv
// Synchronises N_REQ button inputs, latches rising edges as pending requests and grants them
// round-robin to one shared command port. Defining BTN_CMD_ARB_TIMEOUT_EN adds a BUSY-state timeout.
module btn_cmd_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         din,
  output logic                     cmd_valid,
  output logic [$clog2(N_REQ)-1:0] cmd_id,
  input  logic                     cmd_ready,
  input  logic                     cmd_done,
  output logic                     busy,
  output logic [N_REQ-1:0]         pending,
  output logic [N_REQ-1:0]         drop,
  output logic                     timeout_err
);
  localparam int IW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("btn_cmd_arbiter: parameter out of range");
  end

  logic [1:0]       state;
  logic [N_REQ-1:0] s1, s2, s3;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    hi_idx, lo_idx;
  logic             hi_found;
  logic             accept;
  logic             finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise   = s2 & ~s3;
  assign accept = (state == S_OFFER) && cmd_ready;

  always_comb begin
    clr = '0;
    if (accept) clr[cmd_id] = 1'b1;
  end

  // Lowest pending index at/above rr_ptr, otherwise lowest pending index overall (wrap).
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (pending[j]) begin
        lo_idx = IW'(j);
        if (j >= int'(rr_ptr)) begin
          hi_idx   = IW'(j);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  // A new edge on the channel being cleared re-arms it instead of counting as a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      drop    <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      drop    <= drop | (rise & pending & ~clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cmd_id <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|pending) begin
            state  <= S_OFFER;
            cmd_id <= winner;
          end
        end
        S_OFFER: begin
          if (cmd_ready) begin
            state  <= S_BUSY;
            rr_ptr <= (int'(cmd_id) == N_REQ - 1) ? '0 : cmd_id + 1'b1;
          end
        end
        S_BUSY: begin
          if (finish) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid = (state == S_OFFER);
  assign busy      = (state == S_BUSY);

`ifdef BTN_CMD_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        expire;

  // cmd_done on the expiry cycle wins: completion, no error.
  assign expire = (state == S_BUSY) && !cmd_done && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign finish = cmd_done || expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (accept)
        to_cnt <= '0;
      else if (state == S_BUSY)
        to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign finish      = cmd_done;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Directed bench for btn_cmd_arbiter: stimulus pushes expected grant ids, a negedge monitor checks each accept.
module tb_btn_cmd_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] din;
  logic         cmd_valid;
  logic [1:0]   cmd_id;
  logic         cmd_ready;
  logic         cmd_done;
  logic         busy;
  logic [N-1:0] pending;
  logic [N-1:0] drop;
  logic         timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  btn_cmd_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .cmd_valid   (cmd_valid),
    .cmd_id      (cmd_id),
    .cmd_ready   (cmd_ready),
    .cmd_done    (cmd_done),
    .busy        (busy),
    .pending     (pending),
    .drop        (drop),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2ns after the rising edge; outputs are read at the same point.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    din = '0;
    cmd_ready = 1'b0;
    cmd_done = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!cmd_valid && k < 40) begin
      step();
      k++;
    end
    if (!cmd_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_valid: cmd_valid never rose within 40 cycles (t=%0t)", $time);
    end
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      wait_valid();
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      chk("serve_busy", busy, 1);
      cmd_done = 1'b1;
      step();
      cmd_done = 1'b0;
      chk("serve_gap_after_done", cmd_valid, 0);
    end
  endtask

  // Scoreboard monitor: every accept must match the next expected grant.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst && cmd_valid && cmd_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: cmd_id=%0d, no grant expected (t=%0t)", cmd_id, $time);
        end else begin
          e = exp_q.pop_front();
          if (int'(cmd_id) != e) begin
            n_fail++;
            $display("FAIL grant_order: cmd_id=%0d, expected %0d (t=%0t)", cmd_id, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    din = '0;
    cmd_ready = 1'b0;
    cmd_done = 1'b0;
    step(2);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_id", cmd_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_drop", drop, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    step(2);

    // Single request latency
    din = 4'b0100;
    step();                 // E
    step();                 // E+1
    chk("lat_pending_e1", pending, 0);
    step();                 // E+2
    chk("lat_pending_e2", pending, 4);
    chk("lat_valid_e2", cmd_valid, 0);
    step();                 // E+3
    chk("lat_valid_e3", cmd_valid, 1);
    chk("lat_id_e3", cmd_id, 2);
    exp_q.push_back(2);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("single_busy", busy, 1);
    chk("single_valid_low", cmd_valid, 0);
    chk("single_pending_clr", pending, 0);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    chk("single_idle", busy, 0);
    din = '0;
    step(3);

    // Round robin from rr_ptr=0, then wrap
    do_reset();
    din = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    serve(4);
    chk("rr_pending_empty", pending, 0);
    din = '0;
    step(3);
    din = 4'b0001;
    exp_q.push_back(0);
    serve(1);
    din = '0;
    step(3);
    din = 4'b1001;
    exp_q.push_back(3); exp_q.push_back(0);
    serve(2);
    din = '0;
    step(3);

    // Backpressure
    do_reset();
    din = 4'b0010;
    exp_q.push_back(1);
    wait_valid();
    begin
      int stable;
      stable = (cmd_valid && cmd_id == 2'd1) ? 1 : 0;
      repeat (9) begin
        step();
        if (!(cmd_valid && cmd_id == 2'd1)) stable = 0;
      end
      chk("bp_stable_10", stable, 1);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("bp_accept_busy", busy, 1);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    din = '0;
    step(3);

    // Drop while channel 0 is BUSY
    do_reset();
    din = 4'b0001;
    exp_q.push_back(0);
    wait_valid();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    din = 4'b0011;
    step(3);
    chk("drop_first_pending", pending, 2);
    chk("drop_first_none", drop, 0);
    din = 4'b0001;
    step(3);
    din = 4'b0011;
    step(3);
    chk("drop_second_pending", pending, 2);
    chk("drop_flag", drop, 2);
    chk("drop_still_busy", busy, 1);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    exp_q.push_back(1);
    serve(1);
    chk("drop_pending_done", pending, 0);
    chk("drop_sticky", drop, 2);
    din = '0;
    step(3);

    // Edge arriving on the same cycle its grant clears pending
    do_reset();
    din = 4'b0100;
    exp_q.push_back(2);
    wait_valid();
    din = '0;
    step(3);
    din = 4'b0100;
    step();
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("same_busy", busy, 1);
    chk("same_pending_kept", pending, 4);
    chk("same_no_drop", drop, 0);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    exp_q.push_back(2);
    serve(1);
    chk("same_pending_done", pending, 0);
    din = '0;
    step(3);

    // Reset mid-BUSY with din held across release
    do_reset();
    din = 4'b1000;
    exp_q.push_back(3);
    wait_valid();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    din = 4'b1001;
    step(3);
    chk("rstmid_busy", busy, 1);
    chk("rstmid_pending", pending, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy0", busy, 0);
    chk("rstmid_valid0", cmd_valid, 0);
    chk("rstmid_id0", cmd_id, 0);
    chk("rstmid_pending0", pending, 0);
    chk("rstmid_tmo0", timeout_err, 0);
    step(2);
    rst = 1'b0;
    exp_q.push_back(0); exp_q.push_back(3);
    serve(2);
    step(10);
    chk("rstmid_no_extra_valid", cmd_valid, 0);
    chk("rstmid_no_extra_pending", pending, 0);
    din = '0;
    step(3);

    // Timeout behaviour
    do_reset();
    din = 4'b0001;
    exp_q.push_back(0);
    wait_valid();
    cmd_ready = 1'b1;
    step();                 // accept edge A
    cmd_ready = 1'b0;
`ifdef BTN_CMD_ARB_TIMEOUT_EN
    step(7);                // A+7
    chk("tmo_not_yet", timeout_err, 0);
    chk("tmo_busy_before", busy, 1);
    step();                 // A+8
    chk("tmo_pulse", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    step();
    chk("tmo_pulse_one_cycle", timeout_err, 0);
`else
    step(20);
    chk("notmo_busy_held", busy, 1);
    chk("notmo_err_low", timeout_err, 0);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    chk("notmo_done_idle", busy, 0);
`endif
    din = '0;
    step(3);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_cmd_arbiter.md
BTN_CMD_ARBITER -- requirements
Module: btn_cmd_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requester inputs; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, cycles allowed from command accept to cmd_done; legal range 2..65535; used only when BTN_CMD_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all flops on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  N_REQ  raw asynchronous request levels (buttons), one bit per requester.
REQ-006 cmd_valid  output  1  a command is offered to the shared resource.
REQ-007 cmd_id  output  $clog2(N_REQ)  index of the offered requester; valid while cmd_valid is high.
REQ-008 cmd_ready  input  1  the resource accepts the command this cycle.
REQ-009 cmd_done  input  1  one-cycle pulse: the resource has finished the accepted command.
REQ-010 busy  output  1  high from command accept until completion or timeout.
REQ-011 pending  output  N_REQ  per-requester latched, ungranted requests.
REQ-012 drop  output  N_REQ  sticky flag per requester: a rising edge arrived while already pending.
REQ-013 timeout_err  output  1  one-cycle pulse when a command times out.

Function
REQ-014 Each din bit SHALL pass a two-flop synchroniser (s1, s2), then a third flop (s3); edge pulse = s2 & ~s3.
REQ-015 Latency: if din[i] is first sampled high at edge E, pending[i] SHALL set at E+2; with the FSM in IDLE and no other pending request, cmd_valid SHALL be high from E+3.
REQ-016 An edge pulse on a channel whose pending bit is already set SHALL set drop[i] and SHALL NOT queue a second request.
REQ-017 If an edge pulse and the grant-clear for the same channel occur in the same cycle, pending SHALL remain set (the new event wins) and drop SHALL NOT set.
REQ-018 FSM states: IDLE, OFFER, BUSY.
REQ-019 IDLE -> OFFER when any pending bit is set; cmd_id SHALL be registered to the round-robin winner.
REQ-020 Winner = first pending index at or above rr_ptr, searching upward with modulo-N_REQ wrap.
REQ-021 In OFFER, cmd_valid SHALL be high and cmd_id stable until cmd_ready; on cmd_valid & cmd_ready: clear pending[cmd_id], set rr_ptr = (cmd_id+1) mod N_REQ, go to BUSY.
REQ-022 In BUSY, busy SHALL be high and cmd_valid low; cmd_done SHALL return the FSM to IDLE, and the next grant SHALL NOT occur before the following cycle.
REQ-023 cmd_ready outside OFFER and cmd_done outside BUSY SHALL be ignored.
REQ-024 New requests SHALL latch into pending in every state.

Reset
REQ-025 While rst is high: FSM=IDLE, rr_ptr=0, s1/s2/s3=0, pending=0, drop=0, cmd_valid=0, cmd_id=0, busy=0, timeout_err=0.
REQ-026 Reset asserted mid-command SHALL abandon the command with no completion expected; drop flags SHALL clear only on reset.
REQ-027 A din bit held high across reset release SHALL produce exactly one request.

Configuration
REQ-028 Macro BTN_CMD_ARB_TIMEOUT_EN defined: a counter SHALL clear on accept and increment each BUSY cycle. If cmd_done has not arrived by TIMEOUT_CYCLES cycles after accept, timeout_err SHALL pulse for one cycle and the FSM SHALL go to IDLE. cmd_done in the same cycle as expiry counts as completion, with no error.
REQ-029 Macro undefined: no counter is built, BUSY waits indefinitely, and timeout_err is tied to 0.

Verification
REQ-030 Single request: din[2] rises, idle -> pending[2] at E+2, cmd_valid with cmd_id=2 at E+3; cmd_ready=1 -> busy=1; cmd_done -> IDLE, pending=0.
REQ-031 Round robin: din=4'b1111 together, cmd_ready and cmd_done always returned -> grant order 0,1,2,3; then din[0] re-pressed -> grant 0.
REQ-032 Backpressure: cmd_ready held low 10 cycles -> cmd_valid and cmd_id constant for all 10 cycles; accept on cycle 11.
REQ-033 Drop: press din[1] twice while pending[1]=1 and the FSM is in BUSY for channel 0 -> drop[1]=1, one grant for channel 1.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=8): accept with cmd_done withheld -> timeout_err pulse 8 cycles after accept, FSM IDLE; macro off -> busy stays high.
REQ-035 Reset mid-BUSY: assert rst -> all outputs 0 immediately; held-high din after release -> exactly one grant.
